// File: rtl/comparator_arbiter_if.sv
// Request/response bundle between R requesters and the shared comparator arbiter.
// Requester-side signals are packed: slice i of op/a/b belongs to requester i.
interface comparator_arbiter_if #(
  parameter int N = 32,
  parameter int R = 2
);
  logic [R-1:0]   req;
  logic [R-1:0]   s;
  logic [3*R-1:0] op;
  logic [N*R-1:0] a;
  logic [N*R-1:0] b;
  logic [R-1:0]   gnt;
  logic [R-1:0]   vld;
  logic [5:0]     o;
  logic [N-1:0]   flag;
  logic           busy;

  modport master (
    output req, s, op, a, b,
    input  gnt, vld, o, flag, busy
  );

  modport slave (
    input  req, s, op, a, b,
    output gnt, vld, o, flag, busy
  );
endinterface

// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one signed/unsigned comparator between R requesters.
// Returns the 6-bit flag vector {eq,neq,lt,lte,gt,gte} and a Forth boolean.
module comparator #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         s,
  output logic [5:0]   o
);
  logic signed [N:0] ax;
  logic signed [N:0] bx;
  logic              eq;
  logic              lt;
  logic              gt;

  // One extra bit: sign-extend in signed mode, zero-extend otherwise.
  always_comb begin
    ax = {s & a[N-1], a};
    bx = {s & b[N-1], b};
    eq = (a == b);
    lt = (ax < bx);
    gt = !eq && !lt;
    o  = {eq, !eq, lt, lt | eq, gt, gt | eq};
  end
endmodule

module comparator_arbiter #(
  parameter int N = 32,
  parameter int R = 2
) (
  input  logic                clk,
  input  logic                rst,
  comparator_arbiter_if.slave bus
);
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   win_id;
  logic            win_found;
  logic            take;

  logic [N-1:0]    ra_p0;
  logic [N-1:0]    rb_p0;
  logic            rs_p0;
  logic [2:0]      rop_p0;
  logic [IW-1:0]   rid_p0;
  logic [R-1:0]    gnt_p0;

  logic [5:0]      cmp_o;
  logic [5:0]      o_p1;
  logic [N-1:0]    flag_p1;
  logic [R-1:0]    vld_p1;

  function automatic logic sel_flag(input logic [5:0] f, input logic [2:0] op);
    logic bit_sel;
    bit_sel = 1'b0;
    case (op)
      3'd0: bit_sel = f[5];
      3'd1: bit_sel = f[4];
      3'd2: bit_sel = f[3];
      3'd3: bit_sel = f[2];
      3'd4: bit_sel = f[1];
      3'd5: bit_sel = f[0];
      default: bit_sel = 1'b0;
    endcase
    return bit_sel;
  endfunction

  function automatic logic [R-1:0] onehot(input logic [IW-1:0] id);
    return R'(1) << id;
  endfunction

  // Priority starts one past the last winner and wraps modulo R.
  always_comb begin : arb
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 1; i <= R; i++) begin
      idx = (int'(last_q) + i) % R;
      if (!win_found && bus.req[idx[IW-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[IW-1:0];
      end
    end
  end

  assign take = (state_q == IDLE) && win_found;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = CMP;
      CMP:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Stage p0: latch the winner's operands; the comparator only ever sees these.
  always_ff @(posedge clk) begin
    if (take) begin
      ra_p0  <= bus.a[win_id*N +: N];
      rb_p0  <= bus.b[win_id*N +: N];
      rs_p0  <= bus.s[win_id];
      rop_p0 <= bus.op[win_id*3 +: 3];
      rid_p0 <= win_id;
    end
  end

  comparator #(.N(N)) u_cmp (
    .a (ra_p0),
    .b (rb_p0),
    .s (rs_p0),
    .o (cmp_o)
  );

  // Stage p1: register flags and boolean; o/flag hold until the next compare.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q  <= IW'(R - 1);
      gnt_p0  <= '0;
      vld_p1  <= '0;
      o_p1    <= '0;
      flag_p1 <= '0;
    end else begin
      gnt_p0 <= '0;
      vld_p1 <= '0;
      if (take) begin
        gnt_p0 <= onehot(win_id);
        last_q <= win_id;
      end
      if (state_q == CMP) begin
        vld_p1  <= onehot(rid_p0);
        o_p1    <= cmp_o;
        flag_p1 <= {N{sel_flag(cmp_o, rop_p0)}};
      end
    end
  end

  assign bus.gnt  = gnt_p0;
  assign bus.vld  = vld_p1;
  assign bus.o    = o_p1;
  assign bus.flag = flag_p1;
  assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed bench for comparator_arbiter with a cycle-timeline reference model.
module tb_comparator_arbiter;
  localparam int N = 32;
  localparam int R = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  comparator_arbiter_if #(.N(N), .R(R)) bus ();

  comparator_arbiter #(.N(N), .R(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the comparison means, independent of any encoding.
  function automatic logic [5:0] m_flags(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    logic lt, eq, gt;
    eq = (a == b);
    if (s) lt = ($signed(a) < $signed(b));
    else   lt = (a < b);
    gt = !lt && !eq;
    return {eq, !eq, lt, lt || eq, gt, gt || eq};
  endfunction

  function automatic logic [N-1:0] m_bool(input logic [5:0] f, input logic [2:0] op);
    int k;
    if (op > 3'd5) return '0;
    k = 5 - int'(op);
    return f[k] ? {N{1'b1}} : '0;
  endfunction

  // Timeline model: a grant at edge e yields gnt after e, vld after e+1, next arbitration at e+3.
  int           e;
  int           next_free;
  int           last;
  bit           started;
  bit           pend;
  int           pend_edge;
  int           pid;
  logic [5:0]   po;
  logic [N-1:0] pf;
  logic [R-1:0] eg, ev;
  logic [5:0]   eo;
  logic [N-1:0] ef;
  logic         eb;

  initial begin
    e = 0; started = 0; pend = 0; last = R - 1; next_free = 1;
  end

  always @(posedge clk) begin
    e++;
    started = 1;
    if (!rst) begin
      last = R - 1; next_free = e + 1; pend = 0;
      eg = '0; ev = '0; eo = '0; ef = '0; eb = 1'b0;
    end else begin
      eg = '0;
      ev = '0;
      if (pend && e == pend_edge) begin
        ev = R'(1) << pid; eo = po; ef = pf; pend = 0;
      end
      if (e >= next_free && bus.req != '0) begin
        int w;
        w = last;
        for (int k = 1; k <= R; k++) begin
          if (bus.req[(last + k) % R]) begin
            w = (last + k) % R;
            break;
          end
        end
        po = m_flags(bus.a[w*N +: N], bus.b[w*N +: N], bus.s[w]);
        pf = m_bool(po, bus.op[w*3 +: 3]);
        pend = 1; pend_edge = e + 1; pid = w;
        eg = R'(1) << w;
        next_free = e + 3;
        last = w;
      end
      eb = (e < next_free - 1);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_gnt", bus.gnt, eg);
      check("model_vld", bus.vld, ev);
      check("model_o", bus.o, eo);
      check("model_flag", bus.flag, ef);
      check("model_busy", bus.busy, eb);
    end
  end

  task automatic do_req(input int id, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic sv, input logic [2:0] opv,
                        input logic [5:0] xo, input logic [N-1:0] xf);
    int lat;
    bit seen;
    bus.a[id*N +: N] = av;
    bus.b[id*N +: N] = bv;
    bus.s[id]        = sv;
    bus.op[id*3 +: 3] = opv;
    bus.req[id]      = 1'b1;
    lat = 0; seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("gnt_k1", bus.gnt, R'(1) << id);
        bus.a[id*N +: N] = ~av;
        bus.s[id] = ~sv;
      end
      if (bus.vld[id]) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL vld_timeout: requester %0d got no vld within 8 cycles", id);
    end else begin
      check("vld_latency", lat, 2);
      check("lit_o", bus.o, xo);
      check("lit_flag", bus.flag, xf);
    end
    bus.req[id] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gids[$];
    int gcyc[$];
    bit got;
    n_checks = 0; n_fail = 0;
    rst = 1'b0;
    bus.req = 2'b11; bus.s = '0; bus.op = '0; bus.a = '0; bus.b = '0;

    // Reset with requests pending.
    repeat (2) @(negedge clk);
    check("rst_gnt", bus.gnt, 0);
    check("rst_vld", bus.vld, 0);
    check("rst_o", bus.o, 0);
    check("rst_flag", bus.flag, 0);
    check("rst_busy", bus.busy, 0);
    bus.req = 2'b00;
    rst = 1'b1;
    @(negedge clk);

    do_req(0, 32'h0, 32'h1, 1'b0, 3'd2, 6'b011100, 32'hFFFFFFFF);
    do_req(0, 32'hFFFFFFFF, 32'h0, 1'b0, 3'd4, 6'b010011, 32'hFFFFFFFF);
    do_req(0, 32'hFFFFFFFF, 32'h0, 1'b1, 3'd4, 6'b011100, 32'h00000000);
    do_req(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 3'd0, 6'b100101, 32'hFFFFFFFF);
    do_req(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 3'd7, 6'b100101, 32'h00000000);
    do_req(0, 32'h80000000, 32'h1, 1'b1, 3'd3, 6'b011100, 32'hFFFFFFFF);

    // Pointer now at 0: idle reset must bring requester 0 back to top priority.
    rst = 1'b0;
    @(negedge clk);
    bus.a[0 +: N] = 32'h5; bus.b[0 +: N] = 32'h5; bus.op[0 +: 3] = 3'd1; bus.s[0] = 1'b0;
    bus.a[N +: N] = 32'h5; bus.b[N +: N] = 32'h5; bus.op[3 +: 3] = 3'd1; bus.s[1] = 1'b0;
    bus.req = 2'b11;
    rst = 1'b1;
    @(negedge clk);
    check("ptr_reset_gnt", bus.gnt, 2'b01);
    bus.req = 2'b00;
    repeat (3) @(negedge clk);

    do_req(1, 32'h5, 32'h3, 1'b1, 3'd5, 6'b010011, 32'hFFFFFFFF);

    // Both requesters held: grants alternate, each vld carries its own operands.
    bus.a[0 +: N] = 32'h1; bus.b[0 +: N] = 32'h0; bus.s[0] = 1'b0; bus.op[0 +: 3] = 3'd4;
    bus.a[N +: N] = 32'h0; bus.b[N +: N] = 32'h1; bus.s[1] = 1'b0; bus.op[3 +: 3] = 3'd2;
    bus.req = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        gids.push_back(bus.gnt[1] ? 1 : 0);
        gcyc.push_back(c);
      end
      if (bus.vld[0]) check("arb_o_req0", bus.o, 6'b010011);
      if (bus.vld[1]) check("arb_o_req1", bus.o, 6'b011100);
    end
    bus.req = 2'b00;
    check("arb_grant_count", gids.size(), 4);
    foreach (gids[i]) check("arb_grant_id", gids[i], i % 2);
    for (int i = 1; i < gcyc.size(); i++) check("arb_spacing", gcyc[i] - gcyc[i-1], 3);
    repeat (2) @(negedge clk);

    // Reset during CMP of requester 1: its result must never appear.
    bus.a[N +: N] = 32'h3; bus.b[N +: N] = 32'h9; bus.op[3 +: 3] = 3'd2;
    bus.req = 2'b10;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.gnt[1]) begin got = 1; break; end
    end
    check("midop_gnt1_seen", got, 1);
    rst = 1'b0;
    @(negedge clk);
    check("midop_vld", bus.vld, 0);
    check("midop_busy", bus.busy, 0);
    bus.req = 2'b11;
    @(negedge clk);
    check("midop_vld2", bus.vld, 0);
    rst = 1'b1;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.vld[1] && !got) check("midop_no_vld1_before_gnt", bus.vld[1], 0);
      if (bus.gnt != '0) begin
        check("midop_first_gnt", bus.gnt, 2'b01);
        got = 1;
        break;
      end
    end
    check("midop_gnt_seen", got, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.vld[0]) bus.req[0] = 1'b0;
      if (bus.vld[1]) begin
        check("midop_o_req1", bus.o, 6'b011100);
        bus.req[1] = 1'b0;
      end
    end
    bus.req = 2'b00;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
